// File: rtl/sr_drv_pkg.sv
// Shared types and sizing helpers for the NAND SR latch driver.
package sr_drv_pkg;

    // Pulse sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SET_PULSE   = 2'd1,
        ST_RESET_PULSE = 2'd2,
        ST_GAP         = 2'd3
    } state_e;

    // Bits needed for a counter holding values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// One push-button channel: two-flop synchroniser, stability counter and a
// registered single-cycle press event on each debounced 0->1 transition.
module sr_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    import sr_drv_pkg::*;

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [1:0]    valid_q;
    logic          armed_q;
    logic          armed_d;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Stability counter, debounced level and press qualification.
    // A button that is already held when reset releases must be seen
    // released once before it can fire; otherwise a button held through
    // reset would re-launch the pulse that reset just aborted.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        armed_d = armed_q | (valid_q[1] & ~sync2_q);
        press_d = level_q & ~level_prev_q & armed_q;
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            valid_q      <= 2'b00;
            armed_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            valid_q      <= {valid_q[0], 1'b1};
            armed_q      <= armed_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Conditions set/reset push-buttons and drives the active-low set_n/reset_n
// pins of a NAND SR latch with fixed-width, mutually exclusive pulses.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// ST_IDLE        | outputs high, waiting for a press event or pending flag
// ST_SET_PULSE   | set_n held low for PULSE_CYCLES
// ST_RESET_PULSE | reset_n held low for PULSE_CYCLES
// ST_GAP         | both high for GAP_CYCLES; on its last cycle the next
//                | request is decided exactly as in ST_IDLE
module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int GAP_CYCLES      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_reset,
    output logic set_n,
    output logic reset_n,
    output logic busy,
    output logic conflict,
    output logic q_expected
);
    import sr_drv_pkg::*;

    localparam int CW = cnt_width(max2(PULSE_CYCLES, GAP_CYCLES));
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    logic          set_ev;
    logic          rst_ev;
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pend_set_q;
    logic          pend_set_d;
    logic          pend_rst_q;
    logic          pend_rst_d;
    logic          set_n_q;
    logic          set_n_d;
    logic          reset_n_q;
    logic          reset_n_d;
    logic          conflict_q;
    logic          conflict_d;
    logic          q_exp_q;
    logic          q_exp_d;
    logic          want_set;
    logic          want_rst;
    logic          decide;

    sr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_set (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_set),
        .press_o(set_ev)
    );

    sr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_reset (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_reset),
        .press_o(rst_ev)
    );

    // Next-state, pending flags, pulse/gap down-counter and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_set_d = pend_set_q;
        pend_rst_d = pend_rst_q;
        conflict_d = 1'b0;
        q_exp_d    = q_exp_q;
        decide     = 1'b0;
        want_set   = set_ev | pend_set_q;
        want_rst   = rst_ev | pend_rst_q;

        unique case (state_q)
            ST_IDLE: begin
                decide = 1'b1;
            end
            ST_SET_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    q_exp_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESET_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    q_exp_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    decide  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (decide) begin
            if (want_set && want_rst) begin
                // Contradictory requests: drop both rather than guess.
                conflict_d = 1'b1;
                pend_set_d = 1'b0;
                pend_rst_d = 1'b0;
                state_d    = ST_IDLE;
            end else if (want_set) begin
                state_d    = ST_SET_PULSE;
                cnt_d      = PULSE_LOAD;
                pend_set_d = 1'b0;
            end else if (want_rst) begin
                state_d    = ST_RESET_PULSE;
                cnt_d      = PULSE_LOAD;
                pend_rst_d = 1'b0;
            end
        end else begin
            if (set_ev) begin
                pend_set_d = 1'b1;
            end
            if (rst_ev) begin
                pend_rst_d = 1'b1;
            end
        end

        // Both pins derive from the single next-state value, so they can
        // never be low together.
        set_n_d   = (state_d != ST_SET_PULSE);
        reset_n_d = (state_d != ST_RESET_PULSE);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_set_q <= 1'b0;
            pend_rst_q <= 1'b0;
            set_n_q    <= 1'b1;
            reset_n_q  <= 1'b1;
            conflict_q <= 1'b0;
            q_exp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_set_q <= pend_set_d;
            pend_rst_q <= pend_rst_d;
            set_n_q    <= set_n_d;
            reset_n_q  <= reset_n_d;
            conflict_q <= conflict_d;
            q_exp_q    <= q_exp_d;
        end
    end

    assign set_n      = set_n_q;
    assign reset_n    = reset_n_q;
    assign busy       = (state_q != ST_IDLE);
    assign conflict   = conflict_q;
    assign q_expected = q_exp_q;

endmodule
